// File: rtl/sys_pll_reset_sequencer.sv
// sys_pll_reset_sequencer: PLL reset/lock sequencer with retry, stability filter and lock-loss tracking
module sys_pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT       = 50000,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES        = 3
)(
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       reinit,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       lock_fail,
   output logic       lock_lost,
   output logic [3:0] retry_cnt,
   output logic [7:0] loss_cnt,
   output logic [2:0] state
);
   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } st_t;
   st_t st, st_n;
   logic s1, locked_s;
   logic [31:0] cnt, cnt_n;
   logic [3:0] retry_n;
   logic [7:0] loss_n;
   logic lost_n;
   always_comb begin
      st_n = st;
      cnt_n = cnt + 32'd1;
      retry_n = retry_cnt;
      loss_n = loss_cnt;
      lost_n = 1'b0;
      if (reinit) begin
         st_n = RESET_PLL;
         cnt_n = '0;
         retry_n = '0;
      end else begin
         case (st)
            RESET_PLL: if (cnt == 32'(PLL_RST_CYCLES - 1)) begin
               st_n = WAIT_LOCK;
               cnt_n = '0;
            end
            WAIT_LOCK: if (locked_s) begin
               st_n = STABLE;
               cnt_n = '0;
            end else if (cnt == 32'(LOCK_TIMEOUT - 1)) begin
               retry_n = retry_cnt + 4'd1;
               st_n = (retry_n == 4'(MAX_RETRIES)) ? FAIL : RESET_PLL;
               cnt_n = '0;
            end
            STABLE: if (!locked_s) begin
               st_n = WAIT_LOCK;
               cnt_n = '0;
            end else if (cnt == 32'(LOCK_STABLE_CYCLES - 1)) begin
               st_n = RUN;
               cnt_n = '0;
               retry_n = '0;
            end
            RUN: begin
               cnt_n = '0;
               if (!locked_s) begin
                  st_n = RESET_PLL;
                  lost_n = 1'b1;
                  loss_n = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
               end
            end
            FAIL: cnt_n = '0;
            default: begin
               st_n = RESET_PLL;
               cnt_n = '0;
            end
         endcase
      end
   end
   always_ff @(posedge refclk) begin
      if (rst) begin
         st        <= RESET_PLL;
         s1        <= 1'b0;
         locked_s  <= 1'b0;
         cnt       <= '0;
         retry_cnt <= '0;
         loss_cnt  <= '0;
         pll_rst   <= 1'b1;
         sys_reset <= 1'b1;
         lock_fail <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         st        <= st_n;
         s1        <= pll_locked;
         locked_s  <= s1;
         cnt       <= cnt_n;
         retry_cnt <= retry_n;
         loss_cnt  <= loss_n;
         pll_rst   <= (st_n == RESET_PLL) || (st_n == FAIL);
         sys_reset <= st_n != RUN;
         lock_fail <= st_n == FAIL;
         lock_lost <= lost_n;
      end
   end
   assign state = st;
endmodule

// File: tb/tb_sys_pll_reset_sequencer.sv
// tb_sys_pll_reset_sequencer: directed scenario bench for the PLL reset sequencer
module tb_sys_pll_reset_sequencer;
   logic refclk = 1'b0, rst = 1'b1, pll_locked = 1'b0, reinit = 1'b0;
   logic pll_rst, sys_reset, lock_fail, lock_lost;
   logic [3:0] retry_cnt;
   logic [7:0] loss_cnt;
   logic [2:0] state;
   int n = 0, errs = 0;

   sys_pll_reset_sequencer #(
      .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20), .LOCK_STABLE_CYCLES(8), .MAX_RETRIES(2)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .reinit(reinit),
      .pll_rst(pll_rst), .sys_reset(sys_reset), .lock_fail(lock_fail), .lock_lost(lock_lost),
      .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .state(state)
   );

   always #5 refclk = ~refclk;

   task automatic step(input int k);
      repeat (k) begin
         @(posedge refclk);
         #1;
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      reinit = 1'b0;
      pll_locked = 1'b0;
      step(2);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step(2);
      n++; if (state !== 3'd0) begin errs++; $display("FAIL reset_state got %0d exp 0", state); end
      n++; if ({pll_rst, sys_reset, lock_fail, lock_lost} !== 4'b1100) begin errs++; $display("FAIL reset_flags got %b exp 1100", {pll_rst, sys_reset, lock_fail, lock_lost}); end
      n++; if ({retry_cnt, loss_cnt} !== 12'd0) begin errs++; $display("FAIL reset_cnts got retry=%0d loss=%0d exp 0/0", retry_cnt, loss_cnt); end
   endtask

   task automatic test_nominal;
      do_reset;
      step(3);
      n++; if (state !== 3'd0 || pll_rst !== 1'b1) begin errs++; $display("FAIL nom_pulse got state=%0d pll_rst=%b exp 0/1", state, pll_rst); end
      step(1);
      n++; if (state !== 3'd1 || pll_rst !== 1'b0) begin errs++; $display("FAIL nom_wait got state=%0d pll_rst=%b exp 1/0", state, pll_rst); end
      step(6);
      pll_locked = 1'b1;
      step(2);
      n++; if (state !== 3'd1) begin errs++; $display("FAIL nom_sync_delay got %0d exp 1", state); end
      step(1);
      n++; if (state !== 3'd2 || sys_reset !== 1'b1) begin errs++; $display("FAIL nom_stable got state=%0d sys_reset=%b exp 2/1", state, sys_reset); end
      step(7);
      n++; if (state !== 3'd2 || sys_reset !== 1'b1) begin errs++; $display("FAIL nom_stable_end got state=%0d sys_reset=%b exp 2/1", state, sys_reset); end
      step(1);
      n++; if (state !== 3'd3 || sys_reset !== 1'b0 || pll_rst !== 1'b0 || retry_cnt !== 4'd0) begin errs++; $display("FAIL nom_run got state=%0d sys_reset=%b pll_rst=%b retry=%0d exp 3/0/0/0", state, sys_reset, pll_rst, retry_cnt); end
   endtask

   task automatic test_never_lock;
      do_reset;
      step(24);
      n++; if (state !== 3'd0 || retry_cnt !== 4'd1 || pll_rst !== 1'b1) begin errs++; $display("FAIL nl_retry1 got state=%0d retry=%0d pll_rst=%b exp 0/1/1", state, retry_cnt, pll_rst); end
      step(23);
      n++; if (state !== 3'd1 || retry_cnt !== 4'd1) begin errs++; $display("FAIL nl_wait2 got state=%0d retry=%0d exp 1/1", state, retry_cnt); end
      step(1);
      n++; if (state !== 3'd4 || {lock_fail, pll_rst, sys_reset} !== 3'b111 || retry_cnt !== 4'd2) begin errs++; $display("FAIL nl_fail got state=%0d flags=%b retry=%0d exp 4/111/2", state, {lock_fail, pll_rst, sys_reset}, retry_cnt); end
      step(5);
      n++; if (state !== 3'd4 || lock_fail !== 1'b1) begin errs++; $display("FAIL nl_fail_hold got state=%0d lock_fail=%b exp 4/1", state, lock_fail); end
      reinit = 1'b1;
      step(1);
      reinit = 1'b0;
      n++; if (state !== 3'd0 || lock_fail !== 1'b0 || retry_cnt !== 4'd0 || pll_rst !== 1'b1) begin errs++; $display("FAIL reinit_fail got state=%0d lock_fail=%b retry=%0d pll_rst=%b exp 0/0/0/1", state, lock_fail, retry_cnt, pll_rst); end
      step(3);
      n++; if (state !== 3'd0) begin errs++; $display("FAIL reinit_pulse got %0d exp 0", state); end
      step(1);
      n++; if (state !== 3'd1) begin errs++; $display("FAIL reinit_wait got %0d exp 1", state); end
   endtask

   task automatic test_glitch;
      do_reset;
      pll_locked = 1'b1;
      step(8);
      pll_locked = 1'b0;
      step(1);
      pll_locked = 1'b1;
      step(1);
      n++; if (state !== 3'd2 || sys_reset !== 1'b1) begin errs++; $display("FAIL gl_stable got state=%0d sys_reset=%b exp 2/1", state, sys_reset); end
      step(1);
      n++; if (state !== 3'd1 || sys_reset !== 1'b1 || retry_cnt !== 4'd0) begin errs++; $display("FAIL gl_back got state=%0d sys_reset=%b retry=%0d exp 1/1/0", state, sys_reset, retry_cnt); end
      step(1);
      n++; if (state !== 3'd2) begin errs++; $display("FAIL gl_restable got %0d exp 2", state); end
      step(7);
      n++; if (state !== 3'd2 || sys_reset !== 1'b1) begin errs++; $display("FAIL gl_restart got state=%0d sys_reset=%b exp 2/1", state, sys_reset); end
      step(1);
      n++; if (state !== 3'd3 || sys_reset !== 1'b0) begin errs++; $display("FAIL gl_run got state=%0d sys_reset=%b exp 3/0", state, sys_reset); end
   endtask

   task automatic test_loss;
      int bad = 0, k;
      do_reset;
      pll_locked = 1'b1;
      step(13);
      n++; if (state !== 3'd3) begin errs++; $display("FAIL loss_run got %0d exp 3", state); end
      pll_locked = 1'b0;
      step(2);
      n++; if (state !== 3'd3 || lock_lost !== 1'b0) begin errs++; $display("FAIL loss_pre got state=%0d lock_lost=%b exp 3/0", state, lock_lost); end
      step(1);
      n++; if (state !== 3'd0 || lock_lost !== 1'b1 || loss_cnt !== 8'd1 || sys_reset !== 1'b1 || pll_rst !== 1'b1) begin errs++; $display("FAIL loss_edge got state=%0d lost=%b loss=%0d sys_reset=%b pll_rst=%b exp 0/1/1/1/1", state, lock_lost, loss_cnt, sys_reset, pll_rst); end
      step(1);
      n++; if (lock_lost !== 1'b0) begin errs++; $display("FAIL loss_pulse got %b exp 0", lock_lost); end
      for (int i = 2; i <= 256; i++) begin
         pll_locked = 1'b1;
         k = 0;
         while (state !== 3'd3 && k < 50) begin step(1); k++; end
         if (state !== 3'd3) bad++;
         pll_locked = 1'b0;
         k = 0;
         while (lock_lost !== 1'b1 && k < 10) begin step(1); k++; end
         if (lock_lost !== 1'b1) bad++;
         if (i == 255) begin
            n++; if (loss_cnt !== 8'd255) begin errs++; $display("FAIL loss_255 got %0d exp 255", loss_cnt); end
         end
      end
      n++; if (bad !== 0) begin errs++; $display("FAIL loss_loop_timeouts got %0d exp 0", bad); end
      n++; if (loss_cnt !== 8'd255) begin errs++; $display("FAIL loss_sat got %0d exp 255", loss_cnt); end
   endtask

   task automatic test_reinit_run;
      int k = 0;
      pll_locked = 1'b1;
      while (state !== 3'd3 && k < 50) begin step(1); k++; end
      n++; if (state !== 3'd3) begin errs++; $display("FAIL rr_run got %0d exp 3", state); end
      reinit = 1'b1;
      step(1);
      reinit = 1'b0;
      n++; if (state !== 3'd0 || loss_cnt !== 8'd255 || retry_cnt !== 4'd0) begin errs++; $display("FAIL rr_state got state=%0d loss=%0d retry=%0d exp 0/255/0", state, loss_cnt, retry_cnt); end
      n++; if ({pll_rst, sys_reset, lock_fail, lock_lost} !== 4'b1100) begin errs++; $display("FAIL rr_flags got %b exp 1100", {pll_rst, sys_reset, lock_fail, lock_lost}); end
   endtask

   task automatic test_simultaneous;
      rst = 1'b1;
      reinit = 1'b1;
      step(1);
      n++; if (state !== 3'd0 || loss_cnt !== 8'd0 || retry_cnt !== 4'd0) begin errs++; $display("FAIL sim_rst_cnts got state=%0d loss=%0d retry=%0d exp 0/0/0", state, loss_cnt, retry_cnt); end
      n++; if ({pll_rst, sys_reset, lock_fail, lock_lost} !== 4'b1100) begin errs++; $display("FAIL sim_rst_flags got %b exp 1100", {pll_rst, sys_reset, lock_fail, lock_lost}); end
      do_reset;
      step(21);
      pll_locked = 1'b1;
      step(2);
      n++; if (state !== 3'd1 || retry_cnt !== 4'd0) begin errs++; $display("FAIL sim_pre got state=%0d retry=%0d exp 1/0", state, retry_cnt); end
      step(1);
      n++; if (state !== 3'd2 || retry_cnt !== 4'd0) begin errs++; $display("FAIL sim_lock_wins got state=%0d retry=%0d exp 2/0", state, retry_cnt); end
   endtask

   initial begin
      test_reset;
      test_nominal;
      test_never_lock;
      test_glitch;
      test_loss;
      test_reinit_run;
      test_simultaneous;
      $display("End of test - %0d assertions evaluated, %0d failures", n, errs);
      $finish;
   end
endmodule

// File: doc/sys_pll_reset_sequencer.md
SYS_PLL_RESET_SEQUENCER -- requirements
Module: sys_pll_reset_sequencer

Interface
REQ-001 The block SHALL use a single clock, refclk, and a synchronous active-high reset, rst, sampled only on the rising edge of refclk.
REQ-002 The block SHALL provide parameter PLL_RST_CYCLES, default 16: number of cycles pll_rst is held high per PLL reset pulse.
REQ-003 The block SHALL provide parameter LOCK_TIMEOUT, default 50000: number of cycles to wait for lock before a retry.
REQ-004 The block SHALL provide parameter LOCK_STABLE_CYCLES, default 1024: number of cycles of continuous lock required before sys_reset is released.
REQ-005 The block SHALL provide parameter MAX_RETRIES, default 3: number of lock timeouts tolerated before the FAIL state is entered.
REQ-006 The block SHALL have port refclk, input, 1 bit: free-running 50 MHz reference clock.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL have port pll_locked, input, 1 bit: PLL lock indication, asynchronous to refclk.
REQ-009 The block SHALL have port reinit, input, 1 bit: one-cycle software request to restart the sequence.
REQ-010 The block SHALL have port pll_rst, output, 1 bit: reset to the PLL, active high.
REQ-011 The block SHALL have port sys_reset, output, 1 bit: downstream system reset, active high.
REQ-012 The block SHALL have port lock_fail, output, 1 bit: high while in the FAIL state.
REQ-013 The block SHALL have port lock_lost, output, 1 bit: one-cycle pulse when lock drops while in RUN.
REQ-014 The block SHALL have port retry_cnt, output, 4 bits: number of timeouts in the current attempt.
REQ-015 The block SHALL have port loss_cnt, output, 8 bits: saturating count of lock-loss events.
REQ-016 The block SHALL have port state, output, 3 bits, encoded as RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

Function
REQ-017 The block SHALL pass pll_locked through a two-flop synchronizer to produce locked_s; all decisions SHALL use locked_s only.
REQ-018 RESET_PLL SHALL drive pll_rst=1, count PLL_RST_CYCLES cycles, then go to WAIT_LOCK with the timer cleared.
REQ-019 WAIT_LOCK SHALL drive pll_rst=0 and SHALL go to STABLE when locked_s=1.
REQ-020 In WAIT_LOCK, if the timer reaches LOCK_TIMEOUT-1 with locked_s=0, retry_cnt SHALL increment by one.
REQ-021 On that timeout, the next state SHALL be FAIL if the incremented retry_cnt equals MAX_RETRIES, otherwise RESET_PLL.
REQ-022 If locked_s and the timeout occur in the same cycle, lock SHALL win and the next state SHALL be STABLE.
REQ-023 STABLE SHALL count consecutive cycles with locked_s=1 and SHALL go to RUN after LOCK_STABLE_CYCLES cycles.
REQ-024 If locked_s=0 in STABLE, the block SHALL return to WAIT_LOCK with the timer cleared and retry_cnt unchanged.
REQ-025 RUN SHALL drive sys_reset=0 and SHALL clear retry_cnt on entry.
REQ-026 If locked_s=0 in RUN, the block SHALL pulse lock_lost for one cycle, increment loss_cnt (saturating at 255), and go to RESET_PLL.
REQ-027 FAIL SHALL hold pll_rst=1, sys_reset=1 and lock_fail=1 until reinit or rst.
REQ-028 reinit=1 in any state SHALL force RESET_PLL on the next edge, clear retry_cnt and the counters, keep loss_cnt, and take priority over every other transition.
REQ-029 sys_reset SHALL be 1 in every state except RUN.
REQ-030 All outputs SHALL be registered and SHALL change on the same edge as the state transition that defines them.

Reset
REQ-031 While rst=1, the block SHALL set state=RESET_PLL, pll_rst=1, sys_reset=1, lock_fail=0, lock_lost=0, retry_cnt=0, loss_cnt=0, clear all counters, and clear both synchronizer flops.
REQ-032 rst SHALL override reinit and all other inputs.
REQ-033 Deasserting rst mid-sequence SHALL restart from a full PLL_RST_CYCLES pulse.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-034 Nominal: release rst, raise pll_locked at cycle 10 -> pll_rst high for exactly 4 cycles; STABLE reached 3 cycles after the rise; sys_reset falls 8 cycles later; retry_cnt=0.
REQ-035 Never lock: pll_locked held at 0 -> two 20-cycle timeouts, then FAIL with lock_fail=1, retry_cnt=2, pll_rst=1, sys_reset=1.
REQ-036 Glitch in STABLE: drop pll_locked for 1 cycle at stable count 5 -> return to WAIT_LOCK, stable count restarts, sys_reset stays 1.
REQ-037 Loss in RUN: drop pll_locked -> one-cycle lock_lost pulse, loss_cnt 0->1, sys_reset=1 and pll_rst=1 on the same edge; 256 losses -> loss_cnt=255.
REQ-038 Reinit: pulse reinit in FAIL, and separately in RUN -> RESET_PLL next cycle, lock_fail=0, retry_cnt=0, loss_cnt preserved.
REQ-039 Simultaneous: lock arrives on the timeout cycle -> STABLE, retry_cnt unchanged; reinit and rst asserted together -> reset values per REQ-031.
